// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and helpers for the regbank_rdmux slice.
//   DEPTH_DEF/WIDTH_DEF/NUM_RD_DEF : default geometry (32 x 8, 2 read ports)
//   range_ok(addr, depth)           : 1 when addr indexes a real register
//   slice_lo(idx, w)                : low bit of element idx in a flattened bus
package regbank_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int WIDTH_DEF  = 8;
  localparam int NUM_RD_DEF = 2;

  function automatic logic range_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regbank_rdport.sv
// regbank_rdport: one registered read port of the register bank.
// Index mux, range check, write-forwarding compare and the data/valid/err flops.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rd_en, rd_addr      read request for this port
//   regs                full storage array from the top (read-only here)
//   wr_en/addr/data     write port, used only for same-cycle forwarding
//   rd_data/valid/err   registered response, 1-cycle latency
// Build option: REGBANK_FWD_EN selects same-cycle write bypass; without it a
// read racing a write to the same register returns the old contents.
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  output logic                        rd_err
);

`ifdef REGBANK_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic             in_range;
  logic             fwd_hit;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] data_nxt;

  assign in_range = range_ok(32'(rd_addr), DEPTH);

  // Compare-and-select rather than regs[rd_addr]: DEPTH need not be a power
  // of two, so an out-of-range index must never reach the array select.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == AW'(i)) mux_data = regs[i];
  end

  // wr_addr is compared without its own range check: a forwarding hit only
  // matters when rd_addr is in range, and then the two addresses are equal.
  assign fwd_hit  = FWD_EN && wr_en && (wr_addr == rd_addr);
  assign data_nxt = !in_range ? '0 : (fwd_hit ? wr_data : mux_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & ~in_range;
      if (rd_en) rd_data <= data_nxt;
    end
  end

endmodule

// File: rtl/regbank_rdmux.sv
// regbank_rdmux: DEPTH x WIDTH register bank, one synchronous write port and
// NUM_RD independent registered read ports (1-cycle latency, no arbitration).
// Ports:
//   clk, rst_n                 clock, async active-low reset (clears storage too)
//   wr_en, wr_addr, wr_data    write port; out-of-range writes are dropped
//   rd_en[NUM_RD]              per-port read request
//   rd_addr[NUM_RD*AW]         port p at [p*AW +: AW]
//   rd_data[NUM_RD*WIDTH]      port p at [p*WIDTH +: WIDTH], registered
//   rd_valid[NUM_RD]           one-cycle strobe per accepted read
//   rd_err[NUM_RD]             with rd_valid when the address was >= DEPTH
// Build option: REGBANK_FWD_EN enables same-cycle write-to-read forwarding.
module regbank_rdmux
  import regbank_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int NUM_RD = NUM_RD_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_valid,
  output logic [NUM_RD-1:0]       rd_err
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        wr_ok;

  assign wr_ok = wr_en && range_ok(32'(wr_addr), DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_addr == AW'(i)) regs[i] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regbank_rdport #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[slice_lo(p, AW) +: AW]),
      .regs     (regs),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[slice_lo(p, WIDTH) +: WIDTH]),
      .rd_valid (rd_valid[p]),
      .rd_err   (rd_err[p])
    );
  end

endmodule

// File: tb/tb_regbank_rdmux.sv
// Directed bench for regbank_rdmux: three instances share clk/rst_n
//   u_a : default 32 x 8, 2 ports
//   u_b : DEPTH=20 (non power of two) for out-of-range reads/writes
//   u_c : 64 x 16, 4 ports
module tb_regbank_rdmux;

`ifdef REGBANK_FWD_EN
  localparam logic [7:0] HZ = 8'h22;
`else
  localparam logic [7:0] HZ = 8'h11;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int npass  = 0;
  int ntotal = 0;
  bit done   = 1'b0;

  // instance A
  logic        wr_en_a;
  logic [4:0]  wr_addr_a;
  logic [7:0]  wr_data_a;
  logic [1:0]  rd_en_a;
  logic [9:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic [1:0]  rd_valid_a, rd_err_a;
  // instance B
  logic        wr_en_b;
  logic [4:0]  wr_addr_b;
  logic [7:0]  wr_data_b;
  logic [1:0]  rd_en_b;
  logic [9:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic [1:0]  rd_valid_b, rd_err_b;
  // instance C
  logic        wr_en_c;
  logic [5:0]  wr_addr_c;
  logic [15:0] wr_data_c;
  logic [3:0]  rd_en_c;
  logic [23:0] rd_addr_c;
  logic [63:0] rd_data_c;
  logic [3:0]  rd_valid_c, rd_err_c;

  logic [7:0] mb [20];

  regbank_rdmux u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .rd_err(rd_err_a));

  regbank_rdmux #(.DEPTH(20)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .rd_err(rd_err_b));

  regbank_rdmux #(.DEPTH(64), .WIDTH(16), .NUM_RD(4)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .rd_err(rd_err_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    if (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      $error("FAIL timeout: stimulus did not complete");
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0;
    wr_en_a = 0; wr_addr_a = '0; wr_data_a = '0; rd_en_a = '0; rd_addr_a = '0;
    wr_en_b = 0; wr_addr_b = '0; wr_data_b = '0; rd_en_b = '0; rd_addr_b = '0;
    wr_en_c = 0; wr_addr_c = '0; wr_data_c = '0; rd_en_c = '0; rd_addr_c = '0;
    for (int i = 0; i < 20; i++) mb[i] = 8'h00;

    // reset state, before any clock edge
    #2;
    chk("rst_valid_a", rd_valid_a, 2'b00);
    chk("rst_data_a", rd_data_a, 16'h0000);
    chk("rst_err_a", rd_err_a, 2'b00);
    chk("rst_data_c", rd_data_c, 64'h0);
    tick; tick;
    rst_n = 1'b1;

    // first reads after reset: r0 and r31
    rd_en_a = 2'b11; rd_addr_a = {5'd31, 5'd0};
    tick;
    chk("rst_rd_valid", rd_valid_a, 2'b11);
    chk("rst_rd_data", rd_data_a, 16'h0000);
    chk("rst_rd_err", rd_err_a, 2'b00);
    rd_en_a = 2'b00;
    tick;
    chk("valid_drop", rd_valid_a, 2'b00);

    // write r5, r31 then read back on both ports
    wr_en_a = 1; wr_addr_a = 5'd5; wr_data_a = 8'hA5;
    tick;
    wr_addr_a = 5'd31; wr_data_a = 8'h3C;
    tick;
    wr_en_a = 0;
    rd_en_a = 2'b11; rd_addr_a = {5'd31, 5'd5};
    tick;
    chk("wr_rd_data", rd_data_a, 16'h3CA5);
    chk("wr_rd_valid", rd_valid_a, 2'b11);
    rd_en_a = 2'b00;
    tick;
    chk("wr_rd_valid_1cyc", rd_valid_a, 2'b00);
    chk("rd_data_hold", rd_data_a, 16'h3CA5);

    // same-cycle write/read hazard on r7; port1 reads r5 alongside
    wr_en_a = 1; wr_addr_a = 5'd7; wr_data_a = 8'h11;
    tick;
    wr_data_a = 8'h22; rd_en_a = 2'b11; rd_addr_a = {5'd5, 5'd7};
    tick;
    chk("hazard_data", rd_data_a, {8'hA5, HZ});
    wr_en_a = 0; rd_addr_a = {5'd7, 5'd7};
    tick;
    chk("hazard_after", rd_data_a, 16'h2222);
    rd_en_a = 2'b00;

    // DEPTH=20: populate r0 and r19, read addr 25 and r19
    wr_en_b = 1; wr_addr_b = 5'd0; wr_data_b = 8'h01; mb[0] = 8'h01;
    tick;
    wr_addr_b = 5'd19; wr_data_b = 8'h5A; mb[19] = 8'h5A;
    tick;
    wr_en_b = 0; rd_en_b = 2'b11; rd_addr_b = {5'd19, 5'd25};
    tick;
    chk("oor_err", rd_err_b, 2'b01);
    chk("oor_valid", rd_valid_b, 2'b11);
    chk("oor_data", rd_data_b, 16'h5A00);
    rd_en_b = 2'b00;
    tick;
    chk("oor_err_clear", rd_err_b, 2'b00);
    // dropped write to addr 25, then sweep all 20 registers
    wr_en_b = 1; wr_addr_b = 5'd25; wr_data_b = 8'hFF;
    tick;
    wr_en_b = 0; rd_en_b = 2'b11;
    for (int i = 0; i < 20; i += 2) begin
      rd_addr_b = {5'(i + 1), 5'(i)};
      tick;
      chk("oor_wr_sweep", rd_data_b, {mb[i+1], mb[i]});
    end
    rd_en_b = 2'b00;

    // 64 x 16, four ports all reading r63
    wr_en_c = 1; wr_addr_c = 6'd63; wr_data_c = 16'hBEEF;
    tick;
    wr_en_c = 0; rd_en_c = 4'hF; rd_addr_c = {4{6'd63}};
    tick;
    chk("sweep_data", rd_data_c, {4{16'hBEEF}});
    chk("sweep_valid", rd_valid_c, 4'hF);
    chk("sweep_err", rd_err_c, 4'h0);
    rd_en_c = 4'h0;

    // async reset between edges while port0 is reading r5
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd5};
    tick;
    chk("pre_rst_data", rd_data_a, 16'h22A5);
    chk("pre_rst_valid", rd_valid_a, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rd_valid_a, 2'b00);
    chk("async_rst_data", rd_data_a, 16'h0000);
    #2 rst_n = 1'b1;
    tick;
    chk("post_rst_data", rd_data_a, 16'h0000);
    chk("post_rst_valid", rd_valid_a, 2'b01);

    done = 1'b1;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/regbank_rdmux.md
Name: regbank_rdmux

Overview:
- Parametrised register bank with one synchronous write port and NUM_RD independent registered read ports.
- Replaces the fixed 32x8 combinational address-select mux in the processor datapath.
- Feeds operand and address buses in the execute stage.
- Adds write-to-read forwarding, an out-of-range address flag and per-port read valid.

Parameters:
- DEPTH, 32, number of registers (2..256; need not be a power of 2)
- WIDTH, 8, bits per register
- NUM_RD, 2, number of read ports (1..4)
- AW, $clog2(DEPTH), address width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  AW  write register index
- wr_data  in  WIDTH  write data
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*AW  port p occupies [p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  port p occupies [p*WIDTH +: WIDTH]; registered
- rd_valid  out  NUM_RD  per-port; high for one cycle after an accepted read
- rd_err  out  NUM_RD  per-port; high with rd_valid when the address was >= DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous assert, active-low, synchronous deassert handled externally.
- Reset values: all DEPTH registers, rd_data, rd_valid and rd_err are 0.
- Write: on a rising edge with wr_en=1 and wr_addr<DEPTH, reg[wr_addr] <= wr_data.
  - wr_addr>=DEPTH: write silently dropped; no state changes.
- Read latency is 1 cycle. On a rising edge with rd_en[p]=1:
  - rd_valid[p] <= 1.
  - rd_data[p] <= reg[rd_addr[p]].
  - rd_err[p] <= (rd_addr[p]>=DEPTH).
  - If the address is out of range, rd_data[p] <= 0.
- With rd_en[p]=0: rd_valid[p] <= 0 and rd_err[p] <= 0. rd_data[p] holds its last value; no requirement to clear it.
- Independence: ports have no priority and no arbitration. Any number of ports may read the same register in the same cycle, all receiving identical data.
- Simultaneous write and read of the same in-range address, same edge: governed by the optional feature below.
- Reset mid-operation: rst_n low clears everything immediately, including any pending valid. The first read after release returns 0.
- No backpressure: a read is always accepted. The consumer must sample rd_data while rd_valid is high.

Optional Feature:
- Macro: REGBANK_FWD_EN
- Defined: same-cycle bypass. If wr_en=1, wr_addr==rd_addr[p], address in range and rd_en[p]=1, then rd_data[p] <= wr_data (new value).
- Undefined: rd_data[p] <= the old register contents (read-before-write). The write still lands.

Decomposition:
- Package regbank_pkg holds:
  - the default DEPTH/WIDTH/NUM_RD constants
  - a function range_ok(addr, depth)
  - a function slice index helper for the flattened buses
- Sub-module regbank_rdport: one registered read port, comprising the index mux, range check, forwarding compare, and the valid/err flops.
  - Instantiated NUM_RD times by a generate loop.
  - The storage array and write logic stay in the top.

Test Plan:
- Reset: hold rst_n=0, then release; read addr 0 and 31 on both ports -> rd_valid=1 next cycle, rd_data=0x00, rd_err=0.
- Write/read: write 0xA5 to r5 and 0x3C to r31; next cycle read r5 on port0 and r31 on port1 -> 0xA5 and 0x3C, rd_valid=2'b11 exactly one cycle.
- Same-cycle hazard: r7=0x11; write 0x22 to r7 while port0 reads r7 -> 0x22 with REGBANK_FWD_EN, 0x11 without; next read returns 0x22 in both builds.
- Out of range (DEPTH=20): read addr 25 -> rd_err=1, rd_data=0, rd_valid=1; write addr 25 -> all 20 registers unchanged.
- Async reset mid-read: rd_en=1 to r5 (0xA5); drop rst_n between edges -> rd_valid and rd_data clear to 0 immediately, without waiting for an edge.
- Parameter sweep: WIDTH=16, NUM_RD=4, DEPTH=64; all four ports read r63 after writing 0xBEEF -> all four return 0xBEEF in the same cycle.
